// File: rtl/y86_decode_regfile.sv
`default_nettype none
// ============================================================================
// Module   : y86_decode_regfile
// Brief    : Y86-64 decode stage: register file, src/dst select, operand
//            forwarding, load/use detection and the D->E pipeline register.
// Revision : 1.0  initial release
// ============================================================================
module y86_decode_regfile #(
    parameter int                  DATA_W   = 64,
    parameter int                  NREG     = 15,
    parameter int                  RSP_IDX  = 4,
    parameter logic [DATA_W-1:0]   RESET_SP = 'h200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        D_stat,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [3:0]        D_rA,
    input  logic [3:0]        D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic [3:0]        e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valM,
    input  logic              wb_en,
    input  logic              e_bubble_in,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic              load_use,
    output logic [2:0]        E_stat,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB,
    input  logic [3:0]        dbg_idx,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [3:0] c_RNONE   = 4'hF;
    localparam logic [3:0] c_RSP     = 4'(RSP_IDX);
    localparam logic [2:0] c_SAOK    = 3'd1;
    localparam logic [3:0] c_I_NOP   = 4'h1;
    localparam logic [3:0] c_I_CMOV  = 4'h2;
    localparam logic [3:0] c_I_IRMOV = 4'h3;
    localparam logic [3:0] c_I_RMMOV = 4'h4;
    localparam logic [3:0] c_I_MRMOV = 4'h5;
    localparam logic [3:0] c_I_OPQ   = 4'h6;
    localparam logic [3:0] c_I_JXX   = 4'h7;
    localparam logic [3:0] c_I_CALL  = 4'h8;
    localparam logic [3:0] c_I_RET   = 4'h9;
    localparam logic [3:0] c_I_PUSH  = 4'hA;
    localparam logic [3:0] c_I_POP   = 4'hB;

    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [DATA_W-1:0] valc;
        logic [DATA_W-1:0] vala;
        logic [DATA_W-1:0] valb;
        logic [3:0]        dste;
        logic [3:0]        dstm;
        logic [3:0]        srca;
        logic [3:0]        srcb;
    } e_reg_t;

    logic [DATA_W-1:0] r_regs_q [NREG];
    logic [DATA_W-1:0] w_regs_d [NREG];
    e_reg_t            r_e_q;
    e_reg_t            w_e_d;
    logic [3:0]        w_srca;
    logic [3:0]        w_srcb;
    logic [3:0]        w_dste;
    logic [3:0]        w_dstm;
    logic [DATA_W-1:0] w_vala;
    logic [DATA_W-1:0] w_valb;
    logic              w_load_use;

    // Indices at or above NREG (including RNONE) read as zero.
    function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == 4'(i)) v = r_regs_q[i];
        end
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] fwd(input logic [3:0] src);
        if (src == c_RNONE)      return '0;
        else if (src == e_dstE)  return e_valE;
        else if (src == M_dstM)  return m_valM;
        else if (src == M_dstE)  return M_valE;
        else if (src == W_dstM)  return W_valM;
        else if (src == W_dstE)  return W_valE;
        else                     return rf_read(src);
    endfunction

    always_comb begin
        w_srca = c_RNONE;
        w_srcb = c_RNONE;
        w_dste = c_RNONE;
        w_dstm = c_RNONE;
        case (D_icode)
            c_I_CMOV:  begin w_srca = D_rA;  w_dste = D_rB; end
            c_I_IRMOV: begin w_dste = D_rB; end
            c_I_RMMOV: begin w_srca = D_rA;  w_srcb = D_rB; end
            c_I_MRMOV: begin w_srcb = D_rB;  w_dstm = D_rA; end
            c_I_OPQ:   begin w_srca = D_rA;  w_srcb = D_rB;  w_dste = D_rB; end
            c_I_CALL:  begin w_srcb = c_RSP; w_dste = c_RSP; end
            c_I_RET:   begin w_srca = c_RSP; w_srcb = c_RSP; w_dste = c_RSP; end
            c_I_PUSH:  begin w_srca = D_rA;  w_srcb = c_RSP; w_dste = c_RSP; end
            c_I_POP:   begin w_srca = c_RSP; w_srcb = c_RSP; w_dste = c_RSP; w_dstm = D_rA; end
            default:   ;
        endcase
    end

    always_comb begin
        w_vala = ((D_icode == c_I_JXX) || (D_icode == c_I_CALL)) ? D_valP : fwd(w_srca);
        w_valb = fwd(w_srcb);
        w_load_use = ((r_e_q.icode == c_I_MRMOV) || (r_e_q.icode == c_I_POP)) &&
                     (r_e_q.dstm != c_RNONE) &&
                     ((r_e_q.dstm == w_srca) || (r_e_q.dstm == w_srcb));
    end

    always_comb begin
        w_e_d = '{stat: c_SAOK, icode: c_I_NOP, ifun: 4'h0, valc: '0, vala: '0, valb: '0,
                  dste: c_RNONE, dstm: c_RNONE, srca: c_RNONE, srcb: c_RNONE};
        if (rst_n && !w_load_use && !e_bubble_in) begin
            w_e_d = '{stat: D_stat, icode: D_icode, ifun: D_ifun, valc: D_valC,
                      vala: w_vala, valb: w_valb, dste: w_dste, dstm: w_dstm,
                      srca: w_srca, srcb: w_srcb};
        end
    end

    // Port M is applied after port E so popq %rsp keeps the loaded value.
    always_comb begin
        w_regs_d = r_regs_q;
        for (int i = 0; i < NREG; i++) begin
            if (!rst_n) begin
                w_regs_d[i] = (i == RSP_IDX) ? RESET_SP : '0;
            end else if (wb_en) begin
                if (W_dstE == 4'(i)) w_regs_d[i] = W_valE;
                if (W_dstM == 4'(i)) w_regs_d[i] = W_valM;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_regs_q <= w_regs_d;
        r_e_q    <= w_e_d;
    end

    always_comb begin
        dbg_data = rf_read(dbg_idx);
    end

    assign d_srcA   = w_srca;
    assign d_srcB   = w_srcb;
    assign load_use = w_load_use;
    assign E_stat   = r_e_q.stat;
    assign E_icode  = r_e_q.icode;
    assign E_ifun   = r_e_q.ifun;
    assign E_valC   = r_e_q.valc;
    assign E_valA   = r_e_q.vala;
    assign E_valB   = r_e_q.valb;
    assign E_dstE   = r_e_q.dste;
    assign E_dstM   = r_e_q.dstm;
    assign E_srcA   = r_e_q.srca;
    assign E_srcB   = r_e_q.srcb;

endmodule
`default_nettype wire

// File: tb/tb_y86_decode_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_y86_decode_regfile
// Brief    : Scoreboard bench for y86_decode_regfile (NREG=8 build).
// Revision : 1.0  initial release
// ============================================================================
module tb_y86_decode_regfile;

    localparam int c_DW = 64;
    localparam int K_EICODE = 0, K_EDSTE = 1, K_EVALA = 2, K_EVALB = 3, K_ESRCB = 4,
                   K_LDUSE = 5, K_DBG = 6, K_ESTAT = 7, K_EDSTM = 8, K_EVALC = 9,
                   K_DSRCA = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] D_stat;
    logic [3:0] D_icode, D_ifun, D_rA, D_rB;
    logic [c_DW-1:0] D_valC, D_valP;
    logic [3:0] e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [c_DW-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic wb_en, e_bubble_in;
    logic [3:0] d_srcA, d_srcB;
    logic load_use;
    logic [2:0] E_stat;
    logic [3:0] E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [c_DW-1:0] E_valC, E_valA, E_valB;
    logic [3:0] dbg_idx;
    logic [c_DW-1:0] dbg_data;

    y86_decode_regfile #(.DATA_W(c_DW), .NREG(8), .RSP_IDX(4), .RESET_SP(64'h200)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .wb_en(wb_en), .e_bubble_in(e_bubble_in),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .load_use(load_use),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        int              kind;
        logic [c_DW-1:0] exp;
        string           name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [c_DW-1:0] actual(input int kind);
        case (kind)
            K_EICODE: return 64'(E_icode);
            K_EDSTE:  return 64'(E_dstE);
            K_EVALA:  return E_valA;
            K_EVALB:  return E_valB;
            K_ESRCB:  return 64'(E_srcB);
            K_LDUSE:  return 64'(load_use);
            K_DBG:    return dbg_data;
            K_ESTAT:  return 64'(E_stat);
            K_EDSTM:  return 64'(E_dstM);
            K_EVALC:  return E_valC;
            K_DSRCA:  return 64'(d_srcA);
            default:  return 'x;
        endcase
    endfunction

    // Monitor: compare every entry due in the current cycle, away from the edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [c_DW-1:0] a;
                a = actual(sb[i].kind);
                n_tests++;
                if (sb[i].cyc < cyc || a !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s: actual=%0h required=%0h (cycle %0d)",
                             sb[i].name, a, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_v(input int dly, input int kind, input logic [c_DW-1:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + dly; e.kind = kind; e.exp = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic idle();
        D_stat = 3'd1; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
        D_valC = '0; D_valP = '0;
        e_dstE = 4'hF; e_valE = '0; M_dstE = 4'hF; M_valE = '0; M_dstM = 4'hF; m_valM = '0;
        W_dstE = 4'hF; W_valE = '0; W_dstM = 4'hF; W_valM = '0;
        wb_en = 1'b0; e_bubble_in = 1'b0; dbg_idx = 4'h0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_v(0, K_EICODE, 1, "reset_E_icode");
        expect_v(0, K_EDSTE, 64'hF, "reset_E_dstE");
        expect_v(0, K_ESTAT, 1, "reset_E_stat");
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next();
            dbg_idx = 4'(i);
            expect_v(0, K_DBG, (i == 4) ? 64'h200 : 64'h0, $sformatf("reset_reg%0d", i));
        end

        // Write-back, then a disabled write to the same register
        next(); wb_en = 1; W_dstE = 3; W_valE = 7;
        next(); dbg_idx = 3; expect_v(0, K_DBG, 7, "wb_reg3");
        W_dstE = 3; W_valE = 99; wb_en = 0;
        next(); dbg_idx = 3; expect_v(0, K_DBG, 7, "wb_disabled_reg3");

        // Forward priority: e beats M, W_dstE feeds srcB; reg3 becomes 33
        next(); D_icode = 6; D_rA = 2; D_rB = 3;
        e_dstE = 2; e_valE = 11; M_dstM = 2; m_valM = 22; W_dstE = 3; W_valE = 33; wb_en = 1;
        expect_v(0, K_DSRCA, 2, "fwd_d_srcA");
        expect_v(1, K_EVALA, 11, "fwd_e_valA");
        expect_v(1, K_EVALB, 33, "fwd_W_valE_valB");
        expect_v(1, K_EDSTE, 3, "opq_dstE");
        // M_dstM beats M_dstE; W_dstM beats W_dstE
        next(); D_icode = 6; D_rA = 2; D_rB = 3;
        M_dstM = 2; m_valM = 22; M_dstE = 2; M_valE = 44;
        W_dstM = 3; W_valM = 55; W_dstE = 3; W_valE = 66;
        expect_v(1, K_EVALA, 22, "fwd_mvalM_valA");
        expect_v(1, K_EVALB, 55, "fwd_WvalM_valB");
        // No forwards: register-file reads
        next(); D_icode = 6; D_rA = 3; D_rB = 2;
        expect_v(1, K_EVALA, 33, "rf_read_valA");
        expect_v(1, K_EVALB, 0, "rf_read_valB");

        // Load/use: mrmov into 5 followed by OPq using 5
        next(); D_icode = 5; D_rA = 5; D_rB = 6;
        expect_v(0, K_LDUSE, 0, "no_load_use");
        expect_v(1, K_EDSTM, 5, "mrmov_dstM");
        next(); D_icode = 6; D_rA = 5; D_rB = 6;
        expect_v(0, K_LDUSE, 1, "load_use_set");
        expect_v(1, K_EICODE, 1, "load_use_bubble_icode");
        expect_v(1, K_EDSTE, 64'hF, "load_use_bubble_dstE");
        next(); D_icode = 6; D_rA = 5; D_rB = 6; M_dstM = 5; m_valM = 77;
        expect_v(0, K_LDUSE, 0, "load_use_clear");
        expect_v(1, K_EVALA, 77, "load_use_fwd_valA");
        expect_v(1, K_EICODE, 6, "load_use_resume_icode");

        // Call and popq %rsp
        next(); D_icode = 8; D_valP = 64'h40;
        expect_v(1, K_EVALA, 64'h40, "call_valA");
        expect_v(1, K_ESRCB, 4, "call_srcB");
        expect_v(1, K_EDSTE, 4, "call_dstE");
        next(); wb_en = 1; W_dstE = 4; W_valE = 8; W_dstM = 4; W_valM = 9;
        next(); dbg_idx = 4; expect_v(0, K_DBG, 9, "pop_rsp_valM_wins");

        // Out-of-range write dropped, in-range write on the other port kept
        next(); wb_en = 1; W_dstE = 10; W_valE = 64'hAA; W_dstM = 6; W_valM = 5;
        next(); dbg_idx = 10; expect_v(0, K_DBG, 0, "oor_dbg10");
        D_icode = 6; D_rA = 10; D_rB = 6;
        expect_v(1, K_EVALA, 0, "oor_read_valA");
        expect_v(1, K_EVALB, 5, "rf_read_reg6");

        // External bubble over a valid irmov, then the irmov proper
        next(); D_icode = 3; D_rB = 2; D_valC = 123; e_bubble_in = 1;
        expect_v(1, K_EICODE, 1, "bubble_icode");
        expect_v(1, K_EDSTE, 64'hF, "bubble_dstE");
        expect_v(1, K_EVALC, 0, "bubble_valC");
        next(); D_icode = 3; D_rB = 2; D_valC = 123;
        expect_v(1, K_EICODE, 3, "irmov_icode");
        expect_v(1, K_EDSTE, 2, "irmov_dstE");
        expect_v(1, K_EVALC, 123, "irmov_valC");

        // Reset mid-stream discards D and blocks write-back
        next(); D_icode = 6; D_rA = 1; D_rB = 2; wb_en = 1; W_dstE = 1; W_valE = 5; rst_n = 0;
        expect_v(1, K_EICODE, 1, "midreset_icode");
        next(); rst_n = 1; dbg_idx = 1; expect_v(0, K_DBG, 0, "midreset_no_wb");
        next(); dbg_idx = 4; expect_v(0, K_DBG, 64'h200, "midreset_rsp");

        next();
        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: actual=%0d required=0 pending", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/y86_decode_regfile.md
# y86_decode_regfile

Parametrised decode stage for the Y86-64 pipelined processor: register file with reset values, source and destination selection per icode, and five-source operand forwarding. It also owns the D→E pipeline register, with bubble injection and load/use hazard detection. It sits between the fetch D register and the execute stage, and takes write-back directly from the W register.

## Interface
- DATA_W, 64: register and operand width.
- NREG, 15: implemented registers, indices 0..NREG-1, NREG ≤ 15; index 4'hF is RNONE.
- RSP_IDX, 4: stack-pointer index used by call/ret/push/pop.
- RESET_SP, 'h200: reset value of register RSP_IDX; all other registers reset to 0.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- D_stat, D_icode, D_ifun, D_rA, D_rB  in  3/4/4/4/4  decode-register fields.
- D_valC, D_valP  in  DATA_W  constant and next PC.
- e_dstE, e_valE  in  4/DATA_W  execute-stage forward.
- M_dstE, M_valE, M_dstM, m_valM  in  4/DATA_W  memory-stage forwards.
- W_dstE, W_valE, W_dstM, W_valM  in  4/DATA_W  write-back forwards and register write ports.
- wb_en  in  1  write-back enable; 0 while W_stat ≠ AOK.
- e_bubble_in  in  1  external bubble request for E (branch mispredict).
- d_srcA, d_srcB  out  4  selected sources, combinational.
- load_use  out  1  hazard flag to pipeline control (stall F/D), combinational.
- E_stat, E_icode, E_ifun  out  3/4/4  registered.
- E_valC, E_valA, E_valB  out  DATA_W  registered.
- E_dstE, E_dstM, E_srcA, E_srcB  out  4  registered.
- dbg_idx  in  4  debug read index.
- dbg_data  out  DATA_W  combinational register-file contents at dbg_idx, without forwarding; 0 for index ≥ NREG.

## Operation
- Icodes: 0 halt, 1 nop, 2 cmov, 3 irmov, 4 rmmov, 5 mrmov, 6 OPq, 7 jXX, 8 call, 9 ret, A push, B pop.
- srcA: rA for {2,4,6,A}; RSP_IDX for {9,B}; else RNONE.
- srcB: rB for {4,5,6}; RSP_IDX for {8,9,A,B}; else RNONE.
- dstE: rB for {2,3,6}; RSP_IDX for {8,9,A,B}; else RNONE.
- dstM: rA for {5,B}; else RNONE.
- d_valA: D_valP for icode 7 or 8.
  - Otherwise forwarded by first match of srcA against e_dstE, M_dstM, M_dstE, W_dstM, W_dstE.
  - Otherwise the register-file read.
- d_valB: same priority chain on srcB, with no valP case.
- RNONE never matches any forward source, and reading RNONE yields 0.
- Register read of an index ≥ NREG returns 0; writes to such an index are dropped.
- Write-back: at posedge with wb_en=1, write W_valE to W_dstE and W_valM to W_dstM (each skipped if RNONE).
  - If W_dstE = W_dstM, W_valM wins (popq %rsp semantics).
- load_use = 1 when E_icode ∈ {5,B}, E_dstM ≠ RNONE, and E_dstM ∈ {d_srcA, d_srcB}.
- E register, at each posedge:
  - If !rst_n, or load_use, or e_bubble_in: load a bubble.
    - Bubble: stat=1 (AOK), icode=1, ifun=0, valC/valA/valB=0, all dst/src=RNONE.
  - Otherwise load the decoded values.
- E never stalls.

## Timing
- Reset (rst_n=0 at posedge):
  - Registers clear to 0, except RSP_IDX which loads RESET_SP.
  - E outputs take the bubble values.
  - Reset overrides wb_en and any simultaneous write-back.
- Reset mid-stream discards the in-flight D instruction, and no write-back occurs that edge.
- Decode outputs are combinational. D→E latency is 1 cycle.
- A register written at edge N is visible in the array from edge N. Same-cycle readers get the W value through forwarding, so there is no read-during-write hazard.
- load_use and e_bubble_in asserted together insert a single bubble. F/D stalling is external.

## Test plan
- Reset:
  - Stimulus: rst_n=0 for 2 cycles, then release.
  - Required: dbg_data for index 4 = 'h200; all other indices = 0; E_icode=1, E_dstE=RNONE.
- Write-back:
  - Stimulus: wb_en=1, W_dstE=3, W_valE=7.
  - Required: one cycle later, dbg_idx=3 reads 7.
  - Stimulus: wb_en=0 with the same write.
  - Required: no change.
- Forward priority:
  - Stimulus: OPq rA=2, rB=3; e_dstE=2 (valE=11), M_dstM=2 (valM=22), W_dstE=3 (valE=33).
  - Required: E_valA=11, E_valB=33 after one edge.
- Load/use:
  - Stimulus: mrmov into rA=5, followed by OPq rA=5.
  - Required: load_use=1 for one cycle, E receives a bubble, and the next cycle E_valA = m_valM forwarded.
- Call/pop:
  - Stimulus: call with D_valP='h40.
  - Required: E_valA='h40, E_srcB=4, E_dstE=4.
  - Stimulus: popq %rsp with W_dstE=W_dstM=4, W_valE=8, W_valM=9.
  - Required: register 4 reads 9.
- Out-of-range and bubble:
  - Stimulus: NREG=8, write to index 10.
  - Required: dbg_data for index 10 = 0.
  - Stimulus: e_bubble_in=1 with a valid irmov.
  - Required: E_icode=1, E_dstE=RNONE.
